// File: rtl/aes128_pkg.sv
// Shared AES-128 widths, round constants and the GF(2^8) helpers used by the datapath.
package aes128_pkg;

    localparam int NR      = 10;
    localparam int STATE_W = 128;
    localparam int ROUND_W = 4;
    localparam int RCON_W  = 8;

    localparam logic [RCON_W-1:0]  RCON_INIT  = 8'h01;
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NR);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Column bytes are row 0 in [31:24] down to row 3 in [7:0].
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                r[127-8*(rr+4*c) -: 8] = s[127-8*(rr+4*((c+rr)%4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box, one byte in, one byte out, zero latency.
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);

    always_comb begin
        s_o = 8'h00;
        case (a_i)
            8'h00: s_o = 8'h63; 8'h01: s_o = 8'h7c; 8'h02: s_o = 8'h77; 8'h03: s_o = 8'h7b; 8'h04: s_o = 8'hf2; 8'h05: s_o = 8'h6b; 8'h06: s_o = 8'h6f; 8'h07: s_o = 8'hc5;
            8'h08: s_o = 8'h30; 8'h09: s_o = 8'h01; 8'h0a: s_o = 8'h67; 8'h0b: s_o = 8'h2b; 8'h0c: s_o = 8'hfe; 8'h0d: s_o = 8'hd7; 8'h0e: s_o = 8'hab; 8'h0f: s_o = 8'h76;
            8'h10: s_o = 8'hca; 8'h11: s_o = 8'h82; 8'h12: s_o = 8'hc9; 8'h13: s_o = 8'h7d; 8'h14: s_o = 8'hfa; 8'h15: s_o = 8'h59; 8'h16: s_o = 8'h47; 8'h17: s_o = 8'hf0;
            8'h18: s_o = 8'had; 8'h19: s_o = 8'hd4; 8'h1a: s_o = 8'ha2; 8'h1b: s_o = 8'haf; 8'h1c: s_o = 8'h9c; 8'h1d: s_o = 8'ha4; 8'h1e: s_o = 8'h72; 8'h1f: s_o = 8'hc0;
            8'h20: s_o = 8'hb7; 8'h21: s_o = 8'hfd; 8'h22: s_o = 8'h93; 8'h23: s_o = 8'h26; 8'h24: s_o = 8'h36; 8'h25: s_o = 8'h3f; 8'h26: s_o = 8'hf7; 8'h27: s_o = 8'hcc;
            8'h28: s_o = 8'h34; 8'h29: s_o = 8'ha5; 8'h2a: s_o = 8'he5; 8'h2b: s_o = 8'hf1; 8'h2c: s_o = 8'h71; 8'h2d: s_o = 8'hd8; 8'h2e: s_o = 8'h31; 8'h2f: s_o = 8'h15;
            8'h30: s_o = 8'h04; 8'h31: s_o = 8'hc7; 8'h32: s_o = 8'h23; 8'h33: s_o = 8'hc3; 8'h34: s_o = 8'h18; 8'h35: s_o = 8'h96; 8'h36: s_o = 8'h05; 8'h37: s_o = 8'h9a;
            8'h38: s_o = 8'h07; 8'h39: s_o = 8'h12; 8'h3a: s_o = 8'h80; 8'h3b: s_o = 8'he2; 8'h3c: s_o = 8'heb; 8'h3d: s_o = 8'h27; 8'h3e: s_o = 8'hb2; 8'h3f: s_o = 8'h75;
            8'h40: s_o = 8'h09; 8'h41: s_o = 8'h83; 8'h42: s_o = 8'h2c; 8'h43: s_o = 8'h1a; 8'h44: s_o = 8'h1b; 8'h45: s_o = 8'h6e; 8'h46: s_o = 8'h5a; 8'h47: s_o = 8'ha0;
            8'h48: s_o = 8'h52; 8'h49: s_o = 8'h3b; 8'h4a: s_o = 8'hd6; 8'h4b: s_o = 8'hb3; 8'h4c: s_o = 8'h29; 8'h4d: s_o = 8'he3; 8'h4e: s_o = 8'h2f; 8'h4f: s_o = 8'h84;
            8'h50: s_o = 8'h53; 8'h51: s_o = 8'hd1; 8'h52: s_o = 8'h00; 8'h53: s_o = 8'hed; 8'h54: s_o = 8'h20; 8'h55: s_o = 8'hfc; 8'h56: s_o = 8'hb1; 8'h57: s_o = 8'h5b;
            8'h58: s_o = 8'h6a; 8'h59: s_o = 8'hcb; 8'h5a: s_o = 8'hbe; 8'h5b: s_o = 8'h39; 8'h5c: s_o = 8'h4a; 8'h5d: s_o = 8'h4c; 8'h5e: s_o = 8'h58; 8'h5f: s_o = 8'hcf;
            8'h60: s_o = 8'hd0; 8'h61: s_o = 8'hef; 8'h62: s_o = 8'haa; 8'h63: s_o = 8'hfb; 8'h64: s_o = 8'h43; 8'h65: s_o = 8'h4d; 8'h66: s_o = 8'h33; 8'h67: s_o = 8'h85;
            8'h68: s_o = 8'h45; 8'h69: s_o = 8'hf9; 8'h6a: s_o = 8'h02; 8'h6b: s_o = 8'h7f; 8'h6c: s_o = 8'h50; 8'h6d: s_o = 8'h3c; 8'h6e: s_o = 8'h9f; 8'h6f: s_o = 8'ha8;
            8'h70: s_o = 8'h51; 8'h71: s_o = 8'ha3; 8'h72: s_o = 8'h40; 8'h73: s_o = 8'h8f; 8'h74: s_o = 8'h92; 8'h75: s_o = 8'h9d; 8'h76: s_o = 8'h38; 8'h77: s_o = 8'hf5;
            8'h78: s_o = 8'hbc; 8'h79: s_o = 8'hb6; 8'h7a: s_o = 8'hda; 8'h7b: s_o = 8'h21; 8'h7c: s_o = 8'h10; 8'h7d: s_o = 8'hff; 8'h7e: s_o = 8'hf3; 8'h7f: s_o = 8'hd2;
            8'h80: s_o = 8'hcd; 8'h81: s_o = 8'h0c; 8'h82: s_o = 8'h13; 8'h83: s_o = 8'hec; 8'h84: s_o = 8'h5f; 8'h85: s_o = 8'h97; 8'h86: s_o = 8'h44; 8'h87: s_o = 8'h17;
            8'h88: s_o = 8'hc4; 8'h89: s_o = 8'ha7; 8'h8a: s_o = 8'h7e; 8'h8b: s_o = 8'h3d; 8'h8c: s_o = 8'h64; 8'h8d: s_o = 8'h5d; 8'h8e: s_o = 8'h19; 8'h8f: s_o = 8'h73;
            8'h90: s_o = 8'h60; 8'h91: s_o = 8'h81; 8'h92: s_o = 8'h4f; 8'h93: s_o = 8'hdc; 8'h94: s_o = 8'h22; 8'h95: s_o = 8'h2a; 8'h96: s_o = 8'h90; 8'h97: s_o = 8'h88;
            8'h98: s_o = 8'h46; 8'h99: s_o = 8'hee; 8'h9a: s_o = 8'hb8; 8'h9b: s_o = 8'h14; 8'h9c: s_o = 8'hde; 8'h9d: s_o = 8'h5e; 8'h9e: s_o = 8'h0b; 8'h9f: s_o = 8'hdb;
            8'ha0: s_o = 8'he0; 8'ha1: s_o = 8'h32; 8'ha2: s_o = 8'h3a; 8'ha3: s_o = 8'h0a; 8'ha4: s_o = 8'h49; 8'ha5: s_o = 8'h06; 8'ha6: s_o = 8'h24; 8'ha7: s_o = 8'h5c;
            8'ha8: s_o = 8'hc2; 8'ha9: s_o = 8'hd3; 8'haa: s_o = 8'hac; 8'hab: s_o = 8'h62; 8'hac: s_o = 8'h91; 8'had: s_o = 8'h95; 8'hae: s_o = 8'he4; 8'haf: s_o = 8'h79;
            8'hb0: s_o = 8'he7; 8'hb1: s_o = 8'hc8; 8'hb2: s_o = 8'h37; 8'hb3: s_o = 8'h6d; 8'hb4: s_o = 8'h8d; 8'hb5: s_o = 8'hd5; 8'hb6: s_o = 8'h4e; 8'hb7: s_o = 8'ha9;
            8'hb8: s_o = 8'h6c; 8'hb9: s_o = 8'h56; 8'hba: s_o = 8'hf4; 8'hbb: s_o = 8'hea; 8'hbc: s_o = 8'h65; 8'hbd: s_o = 8'h7a; 8'hbe: s_o = 8'hae; 8'hbf: s_o = 8'h08;
            8'hc0: s_o = 8'hba; 8'hc1: s_o = 8'h78; 8'hc2: s_o = 8'h25; 8'hc3: s_o = 8'h2e; 8'hc4: s_o = 8'h1c; 8'hc5: s_o = 8'ha6; 8'hc6: s_o = 8'hb4; 8'hc7: s_o = 8'hc6;
            8'hc8: s_o = 8'he8; 8'hc9: s_o = 8'hdd; 8'hca: s_o = 8'h74; 8'hcb: s_o = 8'h1f; 8'hcc: s_o = 8'h4b; 8'hcd: s_o = 8'hbd; 8'hce: s_o = 8'h8b; 8'hcf: s_o = 8'h8a;
            8'hd0: s_o = 8'h70; 8'hd1: s_o = 8'h3e; 8'hd2: s_o = 8'hb5; 8'hd3: s_o = 8'h66; 8'hd4: s_o = 8'h48; 8'hd5: s_o = 8'h03; 8'hd6: s_o = 8'hf6; 8'hd7: s_o = 8'h0e;
            8'hd8: s_o = 8'h61; 8'hd9: s_o = 8'h35; 8'hda: s_o = 8'h57; 8'hdb: s_o = 8'hb9; 8'hdc: s_o = 8'h86; 8'hdd: s_o = 8'hc1; 8'hde: s_o = 8'h1d; 8'hdf: s_o = 8'h9e;
            8'he0: s_o = 8'he1; 8'he1: s_o = 8'hf8; 8'he2: s_o = 8'h98; 8'he3: s_o = 8'h11; 8'he4: s_o = 8'h69; 8'he5: s_o = 8'hd9; 8'he6: s_o = 8'h8e; 8'he7: s_o = 8'h94;
            8'he8: s_o = 8'h9b; 8'he9: s_o = 8'h1e; 8'hea: s_o = 8'h87; 8'heb: s_o = 8'he9; 8'hec: s_o = 8'hce; 8'hed: s_o = 8'h55; 8'hee: s_o = 8'h28; 8'hef: s_o = 8'hdf;
            8'hf0: s_o = 8'h8c; 8'hf1: s_o = 8'ha1; 8'hf2: s_o = 8'h89; 8'hf3: s_o = 8'h0d; 8'hf4: s_o = 8'hbf; 8'hf5: s_o = 8'he6; 8'hf6: s_o = 8'h42; 8'hf7: s_o = 8'h68;
            8'hf8: s_o = 8'h41; 8'hf9: s_o = 8'h99; 8'hfa: s_o = 8'h2d; 8'hfb: s_o = 8'h0f; 8'hfc: s_o = 8'hb0; 8'hfd: s_o = 8'h54; 8'hfe: s_o = 8'hbb; 8'hff: s_o = 8'h16;
            default: s_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes128_enc_core.sv
// aes128_enc_core: iterative AES-128 encrypt, one round per clock; result strobed 10 edges after accept.
// No backpressure: AES_en is ignored while busy. AES_COMPLEMENTARY_OUT_EN adds inverted ciphertext outputs.
module aes128_enc_core
    import aes128_pkg::*;
(
    input  logic         AES_clk,
    input  logic         AES_rst,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
`ifdef AES_COMPLEMENTARY_OUT_EN
    output logic         AES_data_out_valid,
    output logic [127:0] AES_data_out_complementary,
    output logic         AES_data_out_complementary_valid
`else
    output logic         AES_data_out_valid
`endif
);

    fsm_e                fsm_q, fsm_d;
    logic [ROUND_W-1:0]  round_q, round_d;
    logic [RCON_W-1:0]   rcon_q, rcon_d;
    logic [STATE_W-1:0]  state_q, state_d;
    logic [STATE_W-1:0]  key_q, key_d;
    logic [STATE_W-1:0]  dout_q, dout_d;
    logic                vld_q, vld_d;

    logic [STATE_W-1:0]  sub_bytes, shifted, mixed, round_out, next_key;
    logic [31:0]         rot_w, sub_word, key_temp;
    logic [31:0]         nk0, nk1, nk2, nk3;

    for (genvar i = 0; i < 16; i++) begin : g_subbytes
        aes_sbox u_sbox (.a_i(state_q[127-8*i -: 8]), .s_o(sub_bytes[127-8*i -: 8]));
    end

    assign rot_w = rot_word(key_q[31:0]);

    for (genvar i = 0; i < 4; i++) begin : g_subword
        aes_sbox u_sbox (.a_i(rot_w[31-8*i -: 8]), .s_o(sub_word[31-8*i -: 8]));
    end

    // The key register always holds the key of the round about to be added's predecessor.
    assign key_temp = sub_word ^ {rcon_q, 24'h000000};
    assign nk0      = key_q[127:96] ^ key_temp;
    assign nk1      = key_q[95:64]  ^ nk0;
    assign nk2      = key_q[63:32]  ^ nk1;
    assign nk3      = key_q[31:0]   ^ nk2;
    assign next_key = {nk0, nk1, nk2, nk3};

    assign shifted = shift_rows(sub_bytes);

    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mixed[127-32*c -: 32] = mix_column(shifted[127-32*c -: 32]);
    end

    assign round_out = ((round_q == LAST_ROUND) ? shifted : mixed) ^ next_key;

    always_comb begin
        fsm_d   = fsm_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        state_d = state_q;
        key_d   = key_q;
        dout_d  = dout_q;
        vld_d   = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                if (AES_en) begin
                    state_d = AES_data_in ^ AES_key_in;
                    key_d   = AES_key_in;
                    rcon_d  = RCON_INIT;
                    round_d = ROUND_W'(1);
                    fsm_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = round_out;
                key_d   = next_key;
                rcon_d  = xtime(rcon_q);
                round_d = round_q + 1'b1;
                if (round_q == LAST_ROUND) begin
                    dout_d  = round_out;
                    vld_d   = 1'b1;
                    round_d = '0;
                    fsm_d   = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            fsm_q   <= ST_IDLE;
            round_q <= '0;
            rcon_q  <= '0;
            state_q <= '0;
            key_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            state_q <= state_d;
            key_q   <= key_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
        end
    end

    assign AES_data_out       = dout_q;
    assign AES_data_out_valid = vld_q;

`ifdef AES_COMPLEMENTARY_OUT_EN
    logic [STATE_W-1:0] comp_q;
    logic               comp_vld_q;

    always_ff @(posedge AES_clk) begin
        if (AES_rst) begin
            comp_q     <= '0;
            comp_vld_q <= 1'b0;
        end else begin
            if (vld_d) begin
                comp_q <= ~dout_d;
            end
            comp_vld_q <= vld_d;
        end
    end

    assign AES_data_out_complementary       = comp_q;
    assign AES_data_out_complementary_valid = comp_vld_q;
`endif

endmodule

// File: tb/tb_aes128_enc_core.sv
// Scoreboard bench for aes128_enc_core: FIPS-197 reference model, directed vectors and random traffic.
module tb_aes128_enc_core;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [127:0] din;
    logic [127:0] key;
    logic [127:0] dout;
    logic         vld;
`ifdef AES_COMPLEMENTARY_OUT_EN
    logic [127:0] cdout;
    logic         cvld;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [127:0] data;
        int           edge_n;
    } exp_t;

    exp_t         exp_q[$];
    logic [7:0]   sbox_tab[256];
    int           busy      = 0;
    logic         exp_vld   = 1'b0;
    logic [127:0] exp_hold  = '0;
    logic [127:0] exp_chold = '0;
    logic [127:0] pend      = '0;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    always #5 clk = ~clk;

    aes128_enc_core dut (
        .AES_clk                          (clk),
        .AES_rst                          (rst),
        .AES_en                           (en),
        .AES_data_in                      (din),
        .AES_key_in                       (key),
        .AES_data_out                     (dout),
`ifdef AES_COMPLEMENTARY_OUT_EN
        .AES_data_out_valid               (vld),
        .AES_data_out_complementary       (cdout),
        .AES_data_out_complementary_valid (cvld)
`else
        .AES_data_out_valid               (vld)
`endif
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   w[176];
        logic [7:0]   tmp[4];
        logic [7:0]   a[4];
        logic [7:0]   rc;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127-8*i -: 8];
            w[i] = k[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                a[0]   = tmp[0];
                tmp[0] = sbox_tab[tmp[1]] ^ rc;
                tmp[1] = sbox_tab[tmp[2]];
                tmp[2] = sbox_tab[tmp[3]];
                tmp[3] = sbox_tab[a[0]];
                rc     = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[rr+4*c] = t[rr+4*((c+rr)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = s[4*c+j];
                    s[4*c]   = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
                    s[4*c+1] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
                    s[4*c+2] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
                    s[4*c+3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*rnd+i];
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Transaction-level model: accepts when idle and enabled, completes 10 edges later.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (rst === 1'b1) begin
                busy = 0;
                exp_q.delete();
                exp_vld   = 1'b0;
                exp_hold  = '0;
                exp_chold = '0;
            end else begin
                exp_vld = 1'b0;
                if (busy > 0) begin
                    busy = busy - 1;
                    if (busy == 0) begin
                        exp_vld   = 1'b1;
                        exp_hold  = pend;
                        exp_chold = ~pend;
                    end
                end else if (en === 1'b1) begin
                    pend = aes_ref(din, key);
                    exp_q.push_back('{pend, cyc});
                    busy = 10;
                end
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("valid_level", {127'b0, vld}, {127'b0, exp_vld});
            chk("out_held", dout, exp_hold);
`ifdef AES_COMPLEMENTARY_OUT_EN
            chk("comp_out", cdout, exp_chold);
            chk("comp_valid", {127'b0, cvld}, {127'b0, exp_vld});
`endif
            if (vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got %h expected no result", dout);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", dout, e.data);
                    chk("sb_latency", 128'(cyc), 128'(e.edge_n + 10));
                end
            end
        end
    end

    task automatic start(input logic [127:0] pt, input logic [127:0] k);
        din = pt;
        key = k;
        en  = 1'b1;
        @(posedge clk); #1;
        en  = 1'b0;
        din = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_vld(input int maxc, input logic [127:0] want, input int want_n, input string name);
        int n;
        bit got;
        n = 0;
        got = 0;
        while (!got && n < maxc) begin
            @(negedge clk);
            n++;
            if (vld === 1'b1) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: got no strobe in %0d cycles expected ciphertext %h", name, maxc, want);
        end else begin
            chk(name, dout, want);
            if (want_n > 0) chk({name, "_latency"}, 128'(n), 128'(want_n));
        end
    endtask

    initial begin
        logic [7:0] inv, b;
        int nstr;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox_tab[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end

        rst = 1'b1; en = 1'b0; din = '0; key = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out", dout, 128'h0);
        chk("reset_valid", {127'b0, vld}, 128'h0);
        rst = 1'b0;
        @(negedge clk);

        start(P1, K1);
        wait_vld(15, C1, 11, "vec1");
`ifdef AES_COMPLEMENTARY_OUT_EN
        chk("vec1_comp", cdout, 128'hc6da7be2fd23f60423ee7a68e695f4cd);
        chk("vec1_comp_valid", {127'b0, cvld}, {127'b0, vld});
`endif
        @(negedge clk);
        chk("vec1_strobe_fall", {127'b0, vld}, 128'h0);

        start(P2, K2);
        wait_vld(15, C2, 11, "vec2");
        @(negedge clk);

        nstr = 0;
        din = P1; key = K1;
        for (int i = 0; i < 60; i++) begin
            en = (i < 50);
            @(negedge clk);
            if (vld === 1'b1) begin
                nstr++;
                chk("b2b_data", dout, C1);
            end
        end
        chk("b2b_count", 128'(nstr), 128'((50 - 1) / 11 + 1));

        start(P1, K1);
        for (int i = 0; i < 9; i++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            en  = 1'($urandom);
            @(posedge clk); #1;
        end
        en = 1'b0;
        wait_vld(15, C1, 0, "midrun_inputs");
        @(negedge clk);

        start(P2, K2);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_out", dout, 128'h0);
        chk("abort_valid", {127'b0, vld}, 128'h0);
        nstr = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (vld === 1'b1) nstr++;
        end
        chk("abort_no_strobe", 128'(nstr), 128'h0);
        start(P2, K2);
        wait_vld(15, C2, 11, "after_abort");

        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 3) == 0);
            din = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        en = 1'b0;
        repeat (20) @(negedge clk);
        chk("queue_drained", 128'(exp_q.size()), 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
